// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope stage.
// Scales the NCO's offset-binary samples about mid-scale by an envelope
// that is driven by the note gate. Everything advances only on sample_tick.
module adsr_envelope #(
  parameter int BIT_DEPTH = 8,
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 gate,
  input  logic [ENV_WIDTH-1:0] attack_rate,
  input  logic [ENV_WIDTH-1:0] decay_rate,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_rate,
  input  logic [BIT_DEPTH-1:0] sample_in,
  output logic [BIT_DEPTH-1:0] sample_out,
  output logic                 sample_valid,
  output logic [ENV_WIDTH-1:0] env_level,
  output logic [2:0]           env_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int PROD_W = BIT_DEPTH + 1 + ENV_WIDTH + 1;
  localparam logic [BIT_DEPTH-1:0] HALF    = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

  logic signed [BIT_DEPTH:0]   centred;
  logic signed [ENV_WIDTH:0]   env_signed;
  logic signed [PROD_W-1:0]    product;
  logic        [BIT_DEPTH-1:0] out_next;

  logic [ENV_WIDTH:0]   att_sum;
  logic [ENV_WIDTH:0]   dec_diff;
  logic [ENV_WIDTH:0]   rel_diff;
  logic [ENV_WIDTH-1:0] env_next;
  logic [2:0]           state_next;

  // Output path: signed sample times current envelope, floor-shifted back to offset binary
  always_comb begin
    centred    = $signed({1'b0, sample_in}) - $signed({1'b0, HALF});
    env_signed = $signed({1'b0, env_level});
    product    = PROD_W'(centred) * PROD_W'(env_signed);
    out_next   = BIT_DEPTH'(product >>> ENV_WIDTH) + HALF;
  end

  // Envelope next state: gate events win over rate steps; rate 0 completes the phase at once
  always_comb begin
    att_sum    = {1'b0, env_level} + {1'b0, attack_rate};
    dec_diff   = {1'b0, env_level} - {1'b0, decay_rate};
    rel_diff   = {1'b0, env_level} - {1'b0, release_rate};
    env_next   = env_level;
    state_next = env_state;
    case (env_state)
      ST_IDLE: begin
        env_next = '0;
        if (gate) state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (attack_rate == '0 || att_sum[ENV_WIDTH] ||
                     att_sum[ENV_WIDTH-1:0] == ENV_MAX) begin
          env_next   = ENV_MAX;
          state_next = ST_DECAY;
        end else begin
          env_next = att_sum[ENV_WIDTH-1:0];
        end
      end
      ST_DECAY: begin
        // A borrow or a result at/below sustain both land on sustain, which also
        // covers sustain being raised above the current level mid-decay.
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (decay_rate == '0 || dec_diff[ENV_WIDTH] ||
                     dec_diff[ENV_WIDTH-1:0] <= sustain_level) begin
          env_next   = sustain_level;
          state_next = ST_SUSTAIN;
        end else begin
          env_next = dec_diff[ENV_WIDTH-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!gate) state_next = ST_RELEASE;
        else       env_next   = sustain_level;
      end
      ST_RELEASE: begin
        if (gate) begin
          state_next = ST_ATTACK;
        end else if (release_rate == '0 || rel_diff[ENV_WIDTH] ||
                     rel_diff[ENV_WIDTH-1:0] == '0) begin
          env_next   = '0;
          state_next = ST_IDLE;
        end else begin
          env_next = rel_diff[ENV_WIDTH-1:0];
        end
      end
      default: begin
        env_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registers advance only on sample_tick; sample_valid mirrors the tick one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_state    <= ST_IDLE;
      env_level    <= '0;
      sample_out   <= HALF;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_tick;
      if (sample_tick) begin
        env_state  <= state_next;
        env_level  <= env_next;
        sample_out <= out_next;
      end
    end
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Amplitude envelope stage directly downstream of the NCO.
- Consumes the NCO's unsigned offset-binary samples once per sample period and scales them about mid-scale by an ADSR envelope.
- Envelope is driven by a note gate; output feeds the DAC/PWM output stage.
- Runs on the system clock; sample timing comes from a one-cycle sample strobe.

Parameters:
BIT_DEPTH, 8, sample width; must match the NCO's BIT_DEPTH
ENV_WIDTH, 16, envelope accumulator and rate/level width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle strobe, once per sample period, aligned with NCO output update
gate  input  1  note on (1) / off (0); sampled only on sample_tick
attack_rate  input  ENV_WIDTH  envelope increment per tick in ATTACK
decay_rate  input  ENV_WIDTH  envelope decrement per tick in DECAY
sustain_level  input  ENV_WIDTH  sustain envelope level
release_rate  input  ENV_WIDTH  envelope decrement per tick in RELEASE
sample_in  input  BIT_DEPTH  NCO sample; mid-scale HALF = 2^(BIT_DEPTH-1)
sample_out  output  BIT_DEPTH  enveloped sample
sample_valid  output  1  one-cycle pulse when sample_out updates
env_level  output  ENV_WIDTH  current envelope value
env_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Reset (async, rst_n=0): env_state=IDLE, env_level=0, sample_out=HALF, sample_valid=0.
- All state, env and output updates occur only on clk edges with sample_tick=1. Otherwise all registers hold, and sample_valid=0.
- Output path, on tick:
  - s = sample_in - HALF, signed, BIT_DEPTH+1 bits.
  - p = s * env_level, using env_level before this tick's update.
  - sample_out <= (p >>> ENV_WIDTH) + HALF, floor arithmetic shift.
  - sample_valid <= 1 for exactly one cycle.
  - Latency: one clk from the tick edge.
- Envelope update, one action per tick:
  - A gate event takes priority over a step. On a gate event env_level is unchanged that tick.
  - Gate events:
    - IDLE, gate=1 -> ATTACK.
    - RELEASE, gate=1 -> ATTACK (retrigger), starting from the current env_level, no reset to 0.
    - ATTACK/DECAY/SUSTAIN, gate=0 -> RELEASE.
  - Steps, when there is no gate event:
    - ATTACK: env += attack_rate, saturating at 2^ENV_WIDTH-1. On reaching max -> DECAY (same tick).
    - DECAY: env -= decay_rate, floored at sustain_level. On reaching sustain_level -> SUSTAIN (same tick).
    - SUSTAIN: env <= sustain_level every tick, so it tracks live changes to sustain_level.
    - RELEASE: env -= release_rate, floored at 0. On reaching 0 -> IDLE (same tick).
    - IDLE: env stays 0.
- Rate 0 means instantaneous, not stall:
  - attack_rate=0: env jumps to max.
  - decay_rate=0: env jumps to sustain_level.
  - release_rate=0: env jumps to 0.
  - The normal completion transition follows in the same tick.
- Edge cases:
  - sustain_level=max: DECAY completes on its first step.
  - DECAY entered with env < sustain_level (sustain raised mid-decay): env <= sustain_level -> SUSTAIN.
- Width rules:
  - Saturate and floor using an ENV_WIDTH+1-bit intermediate; no wrap-around in any state.
  - Product width is BIT_DEPTH+1+ENV_WIDTH+1 signed.
- Full-scale gain is (2^ENV_WIDTH-1)/2^ENV_WIDTH. With BIT_DEPTH=8 at max env: sample_in=255 gives 254, and sample_in=0 gives 0.
- Reset asserted mid-note returns immediately to the reset values. After release, the first tick with gate=1 is a gate event into ATTACK.

Test Plan:
- Reset: rst_n=0 mid-ATTACK with env=0x3000 -> env_state=0, env_level=0, sample_out=0x80, sample_valid=0, without waiting for a clk edge.
- Attack/decay/sustain: attack=0x1000, decay=0x0100, sustain=0x8000, gate=1:
  - tick 1 -> ATTACK, env=0;
  - tick 17 -> env=0xFFFF, DECAY;
  - 128 further ticks -> env=0x8000, SUSTAIN.
- Scaling at max env: sample_in=255 -> 254; sample_in=0 -> 0; sample_in=128 -> 128.
- Scaling at env=0x8000: sample_in=255 -> 191; sample_in=0 -> 64. sample_valid pulses once per tick, one cycle after the tick.
- Release and retrigger: from SUSTAIN 0x8000, release=0x2000, gate=0:
  - tick -> RELEASE, env=0x8000;
  - 2 ticks -> env=0x4000;
  - gate=1 -> ATTACK from 0x4000.
  - Separately, letting release complete -> env=0, IDLE, sample_out=0x80.
- Zero rates: attack=decay=release=0, sustain=0x4000:
  - gate=1 -> ATTACK, then the next tick -> env=0xFFFF, DECAY;
  - next -> env=0x4000, SUSTAIN;
  - gate=0 -> RELEASE, then next -> env=0, IDLE.
  - Changing sustain_level to 0x2000 while in SUSTAIN -> env=0x2000 on the next tick.
